// File: rtl/atpg_pkg.sv
// Shared types, constants and width helpers for the launch/capture pattern sequencer.
package atpg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_APPLY_V1 = 2'd1,
    ST_APPLY_V2 = 2'd2,
    ST_DONE     = 2'd3
  } atpg_state_e;

  localparam int              MISR_W    = 16;
  localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

  // Address width for a memory of 'depth' entries, never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold every value 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/atpg_pat_mem.sv
// Pattern store: one {v1, v2, expected} word per pattern, written synchronously,
// read combinationally so the sequencer can drive the DUT in the same cycle.
module atpg_pat_mem
  import atpg_pkg::*;
#(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 1,
  parameter int NUM_PAT = 4,
  localparam int AW     = addr_w(NUM_PAT)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [IN_W-1:0]  i_v1,
  input  logic [IN_W-1:0]  i_v2,
  input  logic [OUT_W-1:0] i_exp,
  input  logic [AW-1:0]    i_raddr,
  output logic [IN_W-1:0]  o_v1,
  output logic [IN_W-1:0]  o_v2,
  output logic [OUT_W-1:0] o_exp
);

  localparam int WORD_W = 2 * IN_W + OUT_W;

  logic [WORD_W-1:0] w_words [NUM_PAT];
  logic [WORD_W-1:0] w_rd_word;

  // No reset on purpose: loaded patterns must survive a sequencer reset.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAT; gi++) begin : g_entry
      logic [WORD_W-1:0] r_word;

      always_ff @(posedge clk) begin
        if (i_we && (i_waddr == AW'(gi))) begin
          r_word <= {i_v1, i_v2, i_exp};
        end
      end

      assign w_words[gi] = r_word;
    end
  endgenerate

  assign w_rd_word = w_words[i_raddr];
  assign o_v1      = w_rd_word[WORD_W-1 -: IN_W];
  assign o_v2      = w_rd_word[OUT_W +: IN_W];
  assign o_exp     = w_rd_word[OUT_W-1:0];

endmodule

// File: rtl/atpg_pair_sequencer.sv
// Two-vector launch/capture pattern applicator with response compare and fail count.
// Optional 16-bit response MISR and 'signature' port when ATPG_MISR_EN is defined.
module atpg_pair_sequencer
  import atpg_pkg::*;
#(
  parameter int IN_W     = 4,
  parameter int OUT_W    = 1,
  parameter int NUM_PAT  = 4,
  parameter int HOLD_CYC = 4,
  parameter int CAP_DLY  = 1,
  localparam int AW      = addr_w(NUM_PAT),
  localparam int NW      = cnt_w(NUM_PAT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NW-1:0]    n_pat,
  input  logic             pat_we,
  input  logic [AW-1:0]    pat_addr,
  input  logic [IN_W-1:0]  pat_v1,
  input  logic [IN_W-1:0]  pat_v2,
  input  logic [OUT_W-1:0] pat_exp,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             resp_valid,
  output logic [AW-1:0]    resp_idx,
  output logic [OUT_W-1:0] resp_data,
  output logic             resp_mismatch,
  output logic [NW-1:0]    fail_cnt
`ifdef ATPG_MISR_EN
  ,
  output logic [MISR_W-1:0] signature
`endif
);

  localparam int CW = cnt_w(max_int(HOLD_CYC, CAP_DLY));

  atpg_state_e      r_state, w_state_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [AW-1:0]    r_idx, w_idx_next;
  logic [AW-1:0]    r_last;
  logic [AW-1:0]    w_last_sel;
  logic             w_start_acc;
  logic             w_capture;
  logic             w_mismatch;
  logic [IN_W-1:0]  w_dut_in;
  logic             w_busy;
  logic             w_done;

  logic             r_resp_valid;
  logic [AW-1:0]    r_resp_idx;
  logic [OUT_W-1:0] r_resp_data;
  logic             r_resp_mismatch;
  logic [NW-1:0]    r_fail_cnt;

  logic [IN_W-1:0]  w_rd_v1;
  logic [IN_W-1:0]  w_rd_v2;
  logic [OUT_W-1:0] w_rd_exp;

  atpg_pat_mem #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .NUM_PAT (NUM_PAT)
  ) u_pat_mem (
    .clk     (clk),
    .i_we    (pat_we && (r_state == ST_IDLE)),
    .i_waddr (pat_addr),
    .i_v1    (pat_v1),
    .i_v2    (pat_v2),
    .i_exp   (pat_exp),
    .i_raddr (r_idx),
    .o_v1    (w_rd_v1),
    .o_v2    (w_rd_v2),
    .o_exp   (w_rd_exp)
  );

  // A zero or oversized request means "run every stored pattern".
  always_comb begin
    w_last_sel = AW'(NUM_PAT - 1);
    if ((n_pat != '0) && (int'(n_pat) <= NUM_PAT)) begin
      w_last_sel = AW'(n_pat - NW'(1));
    end
  end

  assign w_mismatch = (dut_out != w_rd_exp);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_start_acc  = 1'b0;
    w_capture    = 1'b0;
    w_dut_in     = '0;
    w_busy       = 1'b0;
    w_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_state_next = ST_APPLY_V1;
          w_cnt_next   = CW'(HOLD_CYC - 1);
          w_idx_next   = '0;
        end
      end

      ST_APPLY_V1: begin
        w_busy   = 1'b1;
        w_dut_in = w_rd_v1;
        if (r_cnt == '0) begin
          w_state_next = ST_APPLY_V2;
          w_cnt_next   = CW'(CAP_DLY - 1);
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end

      ST_APPLY_V2: begin
        w_busy   = 1'b1;
        w_dut_in = w_rd_v2;
        if (r_cnt == '0) begin
          // Capture edge; the next pattern's V1 follows with no idle gap.
          w_capture = 1'b1;
          if (r_idx == r_last) begin
            w_state_next = ST_DONE;
            w_cnt_next   = '0;
          end else begin
            w_state_next = ST_APPLY_V1;
            w_cnt_next   = CW'(HOLD_CYC - 1);
            w_idx_next   = r_idx + AW'(1);
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end

      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_last          <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_idx      <= '0;
      r_resp_data     <= '0;
      r_resp_mismatch <= 1'b0;
      r_fail_cnt      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_resp_valid <= w_capture;
      if (w_start_acc) begin
        r_last     <= w_last_sel;
        r_fail_cnt <= '0;
      end else if (w_capture) begin
        r_resp_idx      <= r_idx;
        r_resp_data     <= dut_out;
        r_resp_mismatch <= w_mismatch;
        if (w_mismatch) begin
          r_fail_cnt <= r_fail_cnt + NW'(1);
        end
      end
    end
  end

`ifdef ATPG_MISR_EN
  logic [MISR_W-1:0] r_sig;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else if (w_start_acc) begin
      r_sig <= '0;
    end else if (w_capture) begin
      r_sig <= {r_sig[MISR_W-2:0], 1'b0}
             ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
             ^ MISR_W'(dut_out);
    end
  end

  assign signature = r_sig;
`endif

  assign dut_in        = w_dut_in;
  assign busy          = w_busy;
  assign done          = w_done;
  assign resp_valid    = r_resp_valid;
  assign resp_idx      = r_resp_idx;
  assign resp_data     = r_resp_data;
  assign resp_mismatch = r_resp_mismatch;
  assign fail_cnt      = r_fail_cnt;

endmodule

// File: tb/tb_atpg_pair_sequencer.sv
// Bench for atpg_pair_sequencer: a combinational golden DUT with an optional injected
// fault, and a cycle-offset model of when each vector, capture and done must appear.
module tb_atpg_pair_sequencer;

  localparam int IN_W     = 4;
  localparam int OUT_W    = 1;
  localparam int NUM_PAT  = 4;
  localparam int HOLD_CYC = 4;
  localparam int CAP_DLY  = 1;
  localparam int P        = HOLD_CYC + CAP_DLY;
  localparam int AW       = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam int NW       = $clog2(NUM_PAT + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [NW-1:0]    n_pat = '0;
  logic             pat_we = 1'b0;
  logic [AW-1:0]    pat_addr = '0;
  logic [IN_W-1:0]  pat_v1 = '0;
  logic [IN_W-1:0]  pat_v2 = '0;
  logic [OUT_W-1:0] pat_exp = '0;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             resp_valid;
  logic [AW-1:0]    resp_idx;
  logic [OUT_W-1:0] resp_data;
  logic             resp_mismatch;
  logic [NW-1:0]    fail_cnt;
`ifdef ATPG_MISR_EN
  logic [15:0]      signature;
`endif

  int checks = 0;
  int errors = 0;

  // Reference contents of the pattern memory, as the bench believes them to be.
  logic [IN_W-1:0]  m_v1  [NUM_PAT];
  logic [IN_W-1:0]  m_v2  [NUM_PAT];
  logic [OUT_W-1:0] m_exp [NUM_PAT];

  logic             fault_on  = 1'b0;
  logic [IN_W-1:0]  fault_vec = '0;
  logic [15:0]      m_sig;

  always #5 clk = ~clk;

  // Fault-free circuit: out = (a & b) ^ (e | f), with a the MSB of dut_in.
  function automatic logic [OUT_W-1:0] golden(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r    = '0;
    r[0] = (v[3] & v[2]) ^ (v[1] | v[0]);
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] faulty(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = golden(v);
    if (fault_on && (v == fault_vec)) r[0] = ~r[0];
    return r;
  endfunction

  always_comb dut_out = faulty(dut_in);

  atpg_pair_sequencer #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .NUM_PAT  (NUM_PAT),
    .HOLD_CYC (HOLD_CYC),
    .CAP_DLY  (CAP_DLY)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .n_pat         (n_pat),
    .pat_we        (pat_we),
    .pat_addr      (pat_addr),
    .pat_v1        (pat_v1),
    .pat_v2        (pat_v2),
    .pat_exp       (pat_exp),
    .dut_in        (dut_in),
    .dut_out       (dut_out),
    .busy          (busy),
    .done          (done),
    .resp_valid    (resp_valid),
    .resp_idx      (resp_idx),
    .resp_data     (resp_data),
    .resp_mismatch (resp_mismatch),
    .fail_cnt      (fail_cnt)
`ifdef ATPG_MISR_EN
    ,
    .signature     (signature)
`endif
  );

  task automatic load_pat(input int a, input logic [IN_W-1:0] v1,
                          input logic [IN_W-1:0] v2, input logic [OUT_W-1:0] e);
    pat_we   = 1'b1;
    pat_addr = AW'(a);
    pat_v1   = v1;
    pat_v2   = v2;
    pat_exp  = e;
    @(negedge clk);
    pat_we   = 1'b0;
    m_v1[a]  = v1;
    m_v2[a]  = v2;
    m_exp[a] = e;
  endtask

  task automatic load_defaults();
    load_pat(0, 4'b0001, 4'b0110, golden(4'b0110));
    load_pat(1, 4'b0000, 4'b0111, golden(4'b0111));
    load_pat(2, 4'b0001, 4'b0000, golden(4'b0000));
    load_pat(3, 4'b0110, 4'b0001, golden(4'b0001));
  endtask

  // Starts a run at the current negedge and checks every cycle from the start edge E0
  // (offset t) through the first idle cycle. With 'pokes', start and pat_we are pulsed
  // mid-run and start is raised during the done cycle; all of these must be ignored.
  task automatic run_and_check(input int n_req, input bit pokes, input string label);
    int n;
    int k;
    int exp_fail;
    logic [IN_W-1:0]  e_din;
    logic             e_busy, e_done, e_valid, e_mis;
    logic [OUT_W-1:0] e_resp;
    n        = (n_req == 0 || n_req > NUM_PAT) ? NUM_PAT : n_req;
    exp_fail = 0;
    m_sig    = '0;
    n_pat    = NW'(n_req);
    start    = 1'b1;
    @(negedge clk);
    for (int t = 0; t <= n * P; t++) begin
      k       = t / P;
      e_din   = '0;
      e_busy  = 1'b0;
      e_done  = (t == n * P);
      e_valid = (t > 0) && (t % P == 0);
      if (t < n * P) begin
        e_busy = 1'b1;
        e_din  = (t % P < HOLD_CYC) ? m_v1[k] : m_v2[k];
      end
      checks++;
      if ({dut_in, busy, done, resp_valid} !== {e_din, e_busy, e_done, e_valid}) begin
        errors++;
        $display("FAIL %s cycle t=%0d: got dut_in=%b busy=%b done=%b valid=%b, want %b %b %b %b",
                 label, t, dut_in, busy, done, resp_valid, e_din, e_busy, e_done, e_valid);
      end
      if (e_valid) begin
        e_resp = faulty(m_v2[k-1]);
        e_mis  = (e_resp != m_exp[k-1]);
        if (e_mis) exp_fail++;
        m_sig = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ 16'(e_resp);
        checks++;
        if ({resp_idx, resp_data, resp_mismatch} !== {AW'(k-1), e_resp, e_mis}) begin
          errors++;
          $display("FAIL %s resp t=%0d: got idx=%0d data=%h mis=%b, want idx=%0d data=%h mis=%b",
                   label, t, resp_idx, resp_data, resp_mismatch, k-1, e_resp, e_mis);
        end
      end
      if (t == n * P) begin
        checks++;
        if (fail_cnt !== NW'(exp_fail)) begin
          errors++;
          $display("FAIL %s fail_cnt: got %0d want %0d", label, fail_cnt, exp_fail);
        end
`ifdef ATPG_MISR_EN
        checks++;
        if (signature !== m_sig) begin
          errors++;
          $display("FAIL %s signature: got %h want %h", label, signature, m_sig);
        end
`endif
      end
      start  = 1'b0;
      pat_we = 1'b0;
      if (pokes && t == 3) begin
        start    = 1'b1;
        n_pat    = NW'(1);
        pat_we   = 1'b1;
        pat_addr = '0;
        pat_v1   = ~m_v1[0];
        pat_v2   = ~m_v2[0];
        pat_exp  = ~m_exp[0];
      end
      if (pokes && t == n * P) start = 1'b1;
      @(negedge clk);
    end
    start  = 1'b0;
    pat_we = 1'b0;
    checks++;
    if ({dut_in, busy, done, resp_valid} !== {{IN_W{1'b0}}, 3'b000}) begin
      errors++;
      $display("FAIL %s idle after done: got dut_in=%b busy=%b done=%b valid=%b, want all 0",
               label, dut_in, busy, done, resp_valid);
    end
    $display("run %s n_req=%0d patterns=%0d fail_cnt=%0d", label, n_req, n, fail_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dut_in, busy, done, resp_valid, resp_idx, resp_data, resp_mismatch, fail_cnt} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got dut_in=%b busy=%b done=%b valid=%b idx=%0d data=%h mis=%b fail=%0d, want all 0",
               dut_in, busy, done, resp_valid, resp_idx, resp_data, resp_mismatch, fail_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({dut_in, busy, done} !== '0) begin
        errors++;
        $display("FAIL idle cycle %0d: got dut_in=%b busy=%b done=%b, want 0", i, dut_in, busy, done);
      end
    end
    $display("reset/idle checked");
  endtask

  task automatic test_default_run();
    load_defaults();
    run_and_check(4, 1'b0, "default");
  endtask

  task automatic test_fault();
    fault_on  = 1'b1;
    fault_vec = 4'b0000;
    run_and_check(4, 1'b0, "fault");
    checks++;
    if (fail_cnt !== NW'(1)) begin
      errors++;
      $display("FAIL fault fail_cnt: got %0d want 1", fail_cnt);
    end
    fault_on = 1'b0;
  endtask

  task automatic test_npat();
    run_and_check(2, 1'b0, "npat2");
    run_and_check(0, 1'b0, "npat0");
    run_and_check(7, 1'b0, "npat7");
    run_and_check(1, 1'b0, "npat1");
  endtask

  task automatic test_midrun_reset();
    fault_on  = 1'b1;
    fault_vec = m_v2[0];
    n_pat     = '0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (fail_cnt !== NW'(1)) begin
      errors++;
      $display("FAIL midrun fail_cnt before reset: got %0d want 1", fail_cnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({dut_in, busy, done, resp_valid, fail_cnt} !== '0) begin
      errors++;
      $display("FAIL midrun reset: got dut_in=%b busy=%b done=%b valid=%b fail=%0d, want all 0",
               dut_in, busy, done, resp_valid, fail_cnt);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL midrun aftermath cycle %0d: got busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
    fault_on = 1'b0;
    $display("midrun reset checked");
    // Memory must have survived the reset.
    run_and_check(0, 1'b0, "post_reset");
  endtask

  task automatic test_back_to_back();
    run_and_check(3, 1'b1, "pokes");
    run_and_check(0, 1'b0, "b2b");
  endtask

  task automatic test_random();
    logic [IN_W-1:0] v1, v2;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < NUM_PAT; a++) begin
        v1 = IN_W'($urandom);
        v2 = IN_W'($urandom);
        load_pat(a, v1, v2, golden(v2) ^ OUT_W'($urandom_range(0, 3) == 0));
      end
      run_and_check(int'($urandom_range(0, 7)), it[0], "random");
    end
  endtask

`ifdef ATPG_MISR_EN
  task automatic test_misr();
    load_pat(0, 4'b1010, 4'b0001, golden(4'b0001));
    load_pat(1, 4'b0101, 4'b0000, golden(4'b0000));
    load_pat(2, 4'b1111, 4'b0001, golden(4'b0001));
    load_pat(3, 4'b0011, 4'b0001, golden(4'b0001));
    for (int r = 0; r < 2; r++) begin
      run_and_check(4, 1'b0, "misr");
      checks++;
      if (signature !== 16'h000B) begin
        errors++;
        $display("FAIL misr run %0d signature: got %h want 000b", r, signature);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default_run();
    test_fault();
    test_npat();
    test_midrun_reset();
    test_back_to_back();
    test_random();
`ifdef ATPG_MISR_EN
    test_misr();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atpg_pair_sequencer.md
# atpg_pair_sequencer

Synthesizable, parametrised two-vector (launch/capture) ATPG pattern applicator for fault-injection validation of a combinational or injected DUT. Stores up to NUM_PAT pattern pairs with expected responses, applies initialisation vector V1 then launch vector V2 to the DUT inputs, and samples the DUT output a programmable number of cycles after launch. It compares each capture against the expected response, streams per-pattern results and keeps a fail count. It replaces the hand-timed file-based pattern benches, and the fault-injection harness instantiates it around `injection_module`-style DUTs.

## Interface
- `IN_W`, 4, DUT input width (bit IN_W-1 = first DUT input, e.g. a,b,e,f).
- `OUT_W`, 1, DUT output width, 1..16.
- `NUM_PAT`, 4, pattern memory depth, ≥1.
- `HOLD_CYC`, 4, cycles V1 is held before launch, ≥1.
- `CAP_DLY`, 1, cycles from V2 applied to capture edge, ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a run when idle.
- `n_pat`  in  $clog2(NUM_PAT+1)  patterns to run, sampled with start; 0 or >NUM_PAT treated as NUM_PAT.
- `pat_we`  in  1  pattern memory write strobe.
- `pat_addr`  in  $clog2(NUM_PAT) (min 1)  write address.
- `pat_v1`, `pat_v2`  in  IN_W  init / launch vectors.
- `pat_exp`  in  OUT_W  expected fault-free response.
- `dut_in`  out  IN_W  drive to DUT inputs.
- `dut_out`  in  OUT_W  DUT response.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `resp_valid`  out  1  one-cycle pulse per captured pattern.
- `resp_idx`  out  $clog2(NUM_PAT) (min 1)  pattern index of result.
- `resp_data`  out  OUT_W  captured response.
- `resp_mismatch`  out  1  resp_data != pat_exp.
- `fail_cnt`  out  $clog2(NUM_PAT+1)  mismatches in current/last run.
- `signature`  out  16  MISR value (only with ATPG_MISR_EN).

## Operation
- FSM states: IDLE, APPLY_V1, APPLY_V2, DONE.
- IDLE: dut_in = 0. start=1 → APPLY_V1 with idx=0, fail_cnt cleared, signature cleared, n_pat latched.
- APPLY_V1: dut_in = v1[idx] for HOLD_CYC cycles, then APPLY_V2.
- APPLY_V2: dut_in = v2[idx] for CAP_DLY cycles. On the final edge, dut_out is registered into resp_data, mismatch is computed, fail_cnt is incremented on mismatch, and resp_valid is pulsed. If idx is the last index → DONE, else idx+1 and APPLY_V1.
- DONE: one cycle, done=1, dut_in=0, busy=0 → IDLE.
- Counter: one cycle counter, reloaded on each state entry.
- start is ignored while busy.
- pat_we writes only in IDLE; a write while busy is dropped.
- Pattern memory is not reset. Contents survive rst_n.

## Timing
- Reset: all outputs 0, state IDLE, counters 0.
- Start edge E0: from E0, busy=1 and dut_in=v1[0].
- Launch: dut_in=v2[k] from E0+k·P+HOLD_CYC, with P = HOLD_CYC+CAP_DLY.
- Capture: pattern k is captured at edge E0+(k+1)·P. resp_valid/resp_idx/resp_data/resp_mismatch are valid in the following cycle. dut_in switches to v1[k+1] at the same edge, with no gap.
- Last capture: done=1 and busy=0 in the same cycle as the last resp_valid. dut_in=0 from that edge.
- start in the DONE cycle is ignored. A new start is accepted from the next cycle.
- rst_n low mid-run: IDLE at the next edge, no done pulse, fail_cnt=0.
- fail_cnt cannot overflow, since its width covers NUM_PAT.

## Configuration
- `ATPG_MISR_EN` defined: 16-bit MISR, cleared on start. On each capture: sig = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 0) ^ zero-extended resp_data. `signature` holds its value after done.
- `ATPG_MISR_EN` undefined: no MISR logic and no `signature` port.

## Structure
- Package `atpg_pkg`: FSM state enum, `MISR_POLY = 16'h1021`, `MISR_W = 16`, width helper functions.
- One natural sub-module `atpg_pat_mem`: NUM_PAT × (2·IN_W+OUT_W) register file with write port and combinational read.

## Test plan
- Reset/idle: rst_n low 2 cycles → all outputs 0. Then start=0 for 10 cycles → dut_in stays 0.
- Defaults, 4 patterns (a,b,e,f): 0001/0110, 0000/0111, 0001/0000, 0110/0001; exp = golden.
  - Check dut_in changes at E0+4, +5, +9, +10, …
  - Check 4 resp_valid pulses, idx 0..3, done at E0+20 coincident with idx 3.
- Fault detection: stuck-at DUT model flips pattern 2 → resp_mismatch only at idx 2, fail_cnt=1.
- n_pat=2 → only idx 0,1 reported, done at E0+10. n_pat=0 → 4 patterns.
- Mid-run: rst_n low during pattern 1 → IDLE, no done. Also: pat_we while busy leaves memory unchanged (read back via next run), and a start pulse mid-run is ignored.
- With ATPG_MISR_EN, OUT_W=1, responses 1,0,1,1 → signature 16'h000B. Rerun yields identical signature.
